// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the digit-serial BCD subtractor.
// Optional build macro: BCD_SUB_ADD_EN (adds an add/subtract select latched at start).
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_BASE = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return (digit <= DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_sub_serial_if.sv
// Request/result bundle between a control FSM and the digit-serial BCD subtractor.
// Optional build macro: BCD_SUB_ADD_EN (adds the op select signal).
interface bcd_sub_serial_if #(
    parameter int NDIG = 3
);
    // Handshake: start is sampled only while the block is idle (busy=0, done=0);
    // a start seen while busy or during the done cycle is dropped, never queued.
    // busy is high from the cycle after acceptance until done, and done is a
    // single-cycle pulse during which d, bout and err are valid (they then hold).
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                bin;
`ifdef BCD_SUB_ADD_EN
    logic                op;
`endif
    logic [4*NDIG-1:0]   d;
    logic                bout;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, a, b, bin,
`ifdef BCD_SUB_ADD_EN
        output op,
`endif
        input  d, bout, busy, done, err
    );

    modport slave (
        input  start, a, b, bin,
`ifdef BCD_SUB_ADD_EN
        input  op,
`endif
        output d, bout, busy, done, err
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit cell: z = x - y - bi with borrow-out (or x + y + bi with
// carry-out when BCD_SUB_ADD_EN is defined and op=1); inv flags a non-BCD input digit.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
`ifdef BCD_SUB_ADD_EN
    input  logic               op,
`endif
    output logic [DIGIT_W-1:0] z,
    output logic               bo,
    output logic               inv
);

    logic [DIGIT_W:0] diff;
    logic [DIGIT_W:0] sum;

    // 5-bit two's complement: inputs up to 15 keep the difference within -16..15.
    assign diff = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
    assign sum  = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, bi};
    assign inv  = !is_bcd(x) || !is_bcd(y);

    always_comb begin
        z  = diff[DIGIT_W-1:0];
        bo = 1'b0;
`ifdef BCD_SUB_ADD_EN
        if (op) begin
            z = sum[DIGIT_W-1:0];
            if (sum > (DIGIT_W+1)'(BCD_MAX)) begin
                z  = DIGIT_W'(sum - (DIGIT_W+1)'(BCD_BASE));
                bo = 1'b1;
            end
        end else
`endif
        if (diff[DIGIT_W]) begin
            z  = diff[DIGIT_W-1:0] + DIGIT_W'(BCD_BASE);
            bo = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: one digit per clock, LSD first, sticky invalid-digit error.
// Optional build macro: BCD_SUB_ADD_EN (op=1 selects BCD addition, bout becomes carry-out).
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_sub_serial_if.slave  bus,
    output state_e           state_dbg_o
);

    localparam int W     = DIGIT_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             err_q, err_d;
`ifdef BCD_SUB_ADD_EN
    logic             op_q, op_d;
`endif

    logic [DIGIT_W-1:0] cell_x, cell_y, cell_z;
    logic               cell_bo, cell_inv;

    assign cell_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign cell_y = b_q[idx_q*DIGIT_W +: DIGIT_W];

    bcd_digit_sub u_cell (
        .x   (cell_x),
        .y   (cell_y),
        .bi  (borrow_q),
`ifdef BCD_SUB_ADD_EN
        .op  (op_q),
`endif
        .z   (cell_z),
        .bo  (cell_bo),
        .inv (cell_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef BCD_SUB_ADD_EN
            op_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
`ifdef BCD_SUB_ADD_EN
            op_q     <= op_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        err_d    = err_q;
`ifdef BCD_SUB_ADD_EN
        op_d     = op_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    bout_d   = 1'b0;
`ifdef BCD_SUB_ADD_EN
                    op_d     = bus.op;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                d_d[idx_q*DIGIT_W +: DIGIT_W] = cell_z;
                borrow_d = cell_bo;
                err_d    = err_q | cell_inv;
                idx_d    = idx_q + IDX_W'(1);
                // Final digit: publish borrow, and blank the result if any digit was invalid.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    bout_d  = cell_bo;
                    state_d = DONE;
                    if (err_d) begin
                        d_d    = '0;
                        bout_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.d       = d_q;
    assign bus.bout    = bout_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed bench for bcd_sub_serial: hand-computed BCD vectors, handshake timing, error and reset cases.
// Optional build macro: BCD_SUB_ADD_EN (enables the addition vectors).
module tb_bcd_sub_serial;
    import bcd_pkg::*;

    localparam int NDIG = 3;
    localparam int W    = 4 * NDIG;

    logic   clk;
    logic   rst_n;
    state_e state_dbg;
    int     checks;
    int     failures;
    int     lat;
    int     busy_n;

    bcd_sub_serial_if #(.NDIG(NDIG)) bus ();

    bcd_sub_serial #(.NDIG(NDIG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .state_dbg_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present one request, then scramble the operand inputs while the block runs
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input logic opv, output int lat_o, output int busy_o);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
`ifdef BCD_SUB_ADD_EN
        bus.op    = opv;
`else
        if (opv) $display("note: op ignored in subtract-only build");
`endif
        bus.start = 1'b1;
        lat_o  = 0;
        busy_o = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom_range(0, 1));
            lat_o++;
            if (bus.busy) busy_o++;
        end while (!bus.done && lat_o < 20);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] exp_d,
                                input logic exp_bout, input logic exp_err);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_d"},    32'(bus.d),    32'(exp_d));
        check({tag, "_bout"}, 32'(bus.bout), 32'(exp_bout));
        check({tag, "_err"},  32'(bus.err),  32'(exp_err));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
`ifdef BCD_SUB_ADD_EN
        bus.op    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_d",     32'(bus.d),     32'h0);
        check("rst_bout",  32'(bus.bout),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        check("rst_err",   32'(bus.err),   32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;

        // basic subtraction, latency and busy length
        run_op(12'h333, 12'h222, 1'b0, 1'b0, lat, busy_n);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_busy_cycles", 32'(busy_n), 32'd3);
        check_result("t1", 12'h111, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        check("t1_hold_d", 32'(bus.d), 32'h111);
        check("t1_idle", 32'(state_dbg), 32'(IDLE));

        run_op(12'h100, 12'h001, 1'b0, 1'b0, lat, busy_n);
        check_result("t2", 12'h099, 1'b0, 1'b0);

        run_op(12'h222, 12'h333, 1'b0, 1'b0, lat, busy_n);
        check_result("t3a", 12'h889, 1'b1, 1'b0);
        run_op(12'h000, 12'h000, 1'b1, 1'b0, lat, busy_n);
        check_result("t3b", 12'h999, 1'b1, 1'b0);
        run_op(12'h500, 12'h123, 1'b1, 1'b0, lat, busy_n);
        check_result("t3c", 12'h376, 1'b0, 1'b0);
        run_op(12'h999, 12'h999, 1'b0, 1'b0, lat, busy_n);
        check_result("t3d", 12'h000, 1'b0, 1'b0);

        // invalid digit, then recovery
        run_op(12'h00A, 12'h001, 1'b0, 1'b0, lat, busy_n);
        check_result("t4a", 12'h000, 1'b0, 1'b1);
        run_op(12'h005, 12'h003, 1'b0, 1'b0, lat, busy_n);
        check_result("t4b", 12'h002, 1'b0, 1'b0);
        run_op(12'h950, 12'h0B0, 1'b0, 1'b0, lat, busy_n);
        check_result("t4c", 12'h000, 1'b0, 1'b1);

        // start during RUN is dropped
        @(negedge clk);
        bus.a = 12'h444; bus.b = 12'h111; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(bus.busy), 32'd1);
        bus.a = 12'h999; bus.b = 12'h000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_result("t5a", 12'h333, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_no_queue", 32'(bus.busy), 32'd0);
        check("t5_hold_d", 32'(bus.d), 32'h333);

        // asynchronous reset while the second digit is in flight
        bus.a = 12'h777; bus.b = 12'h111; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("t5_mid_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5r_d",     32'(bus.d),     32'h0);
        check("t5r_bout",  32'(bus.bout),  32'h0);
        check("t5r_busy",  32'(bus.busy),  32'h0);
        check("t5r_done",  32'(bus.done),  32'h0);
        check("t5r_err",   32'(bus.err),   32'h0);
        check("t5r_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(12'h654, 12'h321, 1'b0, 1'b0, lat, busy_n);
        check("t5b_latency", 32'(lat), 32'd4);
        check_result("t5b", 12'h333, 1'b0, 1'b0);

`ifdef BCD_SUB_ADD_EN
        run_op(12'h888, 12'h333, 1'b0, 1'b1, lat, busy_n);
        check_result("t6a", 12'h221, 1'b1, 1'b0);
        run_op(12'h222, 12'h333, 1'b0, 1'b1, lat, busy_n);
        check_result("t6b", 12'h555, 1'b0, 1'b0);
        run_op(12'h999, 12'h000, 1'b1, 1'b1, lat, busy_n);
        check_result("t6c", 12'h000, 1'b1, 1'b0);
        run_op(12'h500, 12'h123, 1'b0, 1'b0, lat, busy_n);
        check_result("t6d", 12'h377, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
